// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, threshold flags, optional FWFT read and sticky error flags
module sync_fifo_flags #(
  parameter int WIDTH    = 8,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_en,
  input  logic [WIDTH-1:0] w_data,
  input  logic             r_en,
  output logic [WIDTH-1:0] r_data,
  output logic             r_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);
  localparam int DEPTH = 1 << AW;
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_level
    $error("sync_fifo_flags: AF_LEVEL/AE_LEVEL out of range");
  end
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic [WIDTH-1:0] r_data_q, r_data_d;
  logic             r_valid_q, r_valid_d, ovf_q, ovf_d, udf_q, udf_d, rd_acc, wr_acc;
  logic [AW-1:0]    wr_addr, rd_addr;
  assign wr_addr      = wr_ptr_q[AW-1:0];
  assign rd_addr      = rd_ptr_q[AW-1:0];
  assign empty        = wr_ptr_q == rd_ptr_q;
  assign full         = wr_addr == rd_addr && wr_ptr_q[AW] != rd_ptr_q[AW];
  assign count        = count_q;
  assign almost_full  = count_q >= (AW+1)'(AF_LEVEL);
  assign almost_empty = count_q <= (AW+1)'(AE_LEVEL);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign r_data       = FWFT != 0 ? (empty ? '0 : mem[rd_addr]) : r_data_q;
  assign r_valid      = FWFT != 0 ? ~empty : r_valid_q;
  // A write into a full FIFO slips in only when the head is popped in the same cycle
  always_comb begin
    rd_acc    = r_en & ~empty;
    wr_acc    = w_en & (~full | rd_acc);
    wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(rd_acc);
    count_d   = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    r_data_d  = rd_acc ? mem[rd_addr] : r_data_q;
    r_valid_d = rd_acc;
    ovf_d     = (ovf_q & ~clr_err) | (w_en & ~wr_acc);
    udf_d     = (udf_q & ~clr_err) | (r_en & ~rd_acc);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= w_data;
  end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: drives a registered-read and an FWFT instance in parallel against a queue model
module tb_sync_fifo_flags;
  logic clk = 0, rst = 0, w_en = 0, r_en = 0, clr_err = 0;
  logic [7:0] w_data = 0;
  logic [7:0] r_data0, r_data1;
  logic [4:0] count0, count1;
  logic r_valid0, full0, empty0, af0, ae0, ovf0, udf0;
  logic r_valid1, full1, empty1, af1, ae1, ovf1, udf1;
  int errors = 0, checks = 0;
  logic [7:0] q[$];
  logic [7:0] m_rd = 0;
  bit m_rv = 0, m_ovf = 0, m_udf = 0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.FWFT(0)) u0 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data0), .r_valid(r_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(count0),
    .overflow(ovf0), .underflow(udf0), .clr_err(clr_err));
  sync_fifo_flags #(.FWFT(1)) u1 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data1), .r_valid(r_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(count1),
    .overflow(ovf1), .underflow(udf1), .clr_err(clr_err));

  // Drive one cycle, advance the model on pre-edge occupancy, then settle past the edge
  task automatic drive(input bit w, input bit r, input logic [7:0] d, input bit c);
    int n;
    bit ra, wa;
    w_en = w; r_en = r; w_data = d; clr_err = c;
    @(posedge clk);
    n = q.size();
    ra = r && n > 0;
    wa = w && (n < 16 || ra);
    m_rv = ra;
    if (ra) m_rd = q.pop_front();
    if (wa) q.push_back(d);
    m_ovf = (m_ovf && !c) || (w && !wa);
    m_udf = (m_udf && !c) || (r && !ra);
    #1;
    w_en = 0; r_en = 0; clr_err = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #2;
    checks++; if (count0 !== 5'd0 || count1 !== 5'd0) begin errors++; $display("FAIL reset_count act=%0d/%0d exp=0", count0, count1); end
    checks++; if ({empty0, full0, ae0, af0} !== 4'b1010) begin errors++; $display("FAIL reset_flags act=%b exp=1010", {empty0, full0, ae0, af0}); end
    checks++; if ({r_valid0, r_valid1, ovf0, udf0} !== 4'b0000) begin errors++; $display("FAIL reset_valid_err act=%b exp=0000", {r_valid0, r_valid1, ovf0, udf0}); end
    checks++; if (r_data0 !== 8'h00) begin errors++; $display("FAIL reset_rdata act=%h exp=00", r_data0); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'(i), 0);
      checks++; if (count0 !== 5'(i + 1)) begin errors++; $display("FAIL fill_count act=%0d exp=%0d", count0, i + 1); end
      checks++; if ({full0, empty0, af0, ae0} !== {i == 15, 1'b0, i + 1 >= 12, i + 1 <= 2}) begin errors++; $display("FAIL fill_flags i=%0d act=%b exp=%b", i, {full0, empty0, af0, ae0}, {i == 15, 1'b0, i + 1 >= 12, i + 1 <= 2}); end
      checks++; if (r_data1 !== 8'h00 || r_valid1 !== 1'b1) begin errors++; $display("FAIL fill_fwft_head act=%h/%b exp=00/1", r_data1, r_valid1); end
    end
    drive(1, 0, 8'h99, 0);
    checks++; if (ovf0 !== 1'b1 || count0 !== 5'd16) begin errors++; $display("FAIL overflow act=%b/%0d exp=1/16", ovf0, count0); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'h00, 0);
      checks++; if (r_valid0 !== 1'b1 || r_data0 !== 8'(i)) begin errors++; $display("FAIL drain_data act=%h/%b exp=%h/1", r_data0, r_valid0, 8'(i)); end
      checks++; if (count0 !== 5'(15 - i) || empty0 !== (i == 15)) begin errors++; $display("FAIL drain_count act=%0d/%b exp=%0d/%b", count0, empty0, 15 - i, i == 15); end
    end
    drive(0, 1, 8'h00, 0);
    checks++; if (udf0 !== 1'b1 || r_valid0 !== 1'b0 || r_data0 !== 8'h0F) begin errors++; $display("FAIL underflow act=%b/%b/%h exp=1/0/0f", udf0, r_valid0, r_data0); end
    drive(0, 0, 8'h00, 1);
    checks++; if (ovf0 !== 1'b0 || udf0 !== 1'b0) begin errors++; $display("FAIL clr_err act=%b%b exp=00", ovf0, udf0); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 16; i++) drive(1, 0, 8'(8'h10 + i), 0);
    drive(1, 1, 8'hAA, 0);
    checks++; if (count0 !== 5'd16 || full0 !== 1'b1 || ovf0 !== 1'b0) begin errors++; $display("FAIL full_rw_state act=%0d/%b/%b exp=16/1/0", count0, full0, ovf0); end
    checks++; if (r_data0 !== 8'h10 || r_data1 !== 8'h11) begin errors++; $display("FAIL full_rw_pop act=%h/%h exp=10/11", r_data0, r_data1); end
    for (int i = 0; i < 16; i++) drive(0, 1, 8'h00, 0);
    checks++; if (r_data0 !== 8'hAA || empty0 !== 1'b1) begin errors++; $display("FAIL full_rw_tail act=%h/%b exp=aa/1", r_data0, empty0); end
  endtask

  task automatic test_empty_rw();
    drive(1, 1, 8'h55, 0);
    checks++; if (count0 !== 5'd1 || udf0 !== 1'b1 || r_valid0 !== 1'b0) begin errors++; $display("FAIL empty_rw act=%0d/%b/%b exp=1/1/0", count0, udf0, r_valid0); end
    drive(0, 1, 8'h00, 0);
    checks++; if (r_data0 !== 8'h55 || r_valid0 !== 1'b1) begin errors++; $display("FAIL empty_rw_read act=%h/%b exp=55/1", r_data0, r_valid0); end
    drive(0, 1, 8'h00, 1);
    checks++; if (udf0 !== 1'b1) begin errors++; $display("FAIL set_wins_clr act=%b exp=1", udf0); end
    drive(0, 0, 8'h00, 1);
    checks++; if (udf0 !== 1'b0) begin errors++; $display("FAIL clr_udf act=%b exp=0", udf0); end
  endtask

  task automatic test_fwft();
    drive(1, 0, 8'h3C, 0);
    checks++; if (r_data1 !== 8'h3C || r_valid1 !== 1'b1 || r_valid0 !== 1'b0) begin errors++; $display("FAIL fwft_show act=%h/%b/%b exp=3c/1/0", r_data1, r_valid1, r_valid0); end
    drive(0, 1, 8'h00, 0);
    checks++; if (empty1 !== 1'b1 || r_valid1 !== 1'b0) begin errors++; $display("FAIL fwft_pop act=%b/%b exp=1/0", empty1, r_valid1); end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 15) == 0);
      n = q.size();
      checks++; if (count0 !== 5'(n) || count1 !== 5'(n)) begin errors++; $display("FAIL rnd_count cyc=%0d act=%0d/%0d exp=%0d", i, count0, count1, n); end
      checks++; if ({full0, empty0, af0, ae0, ovf0, udf0} !== {n == 16, n == 0, n >= 12, n <= 2, m_ovf, m_udf}) begin errors++; $display("FAIL rnd_flags cyc=%0d act=%b exp=%b", i, {full0, empty0, af0, ae0, ovf0, udf0}, {n == 16, n == 0, n >= 12, n <= 2, m_ovf, m_udf}); end
      checks++; if (r_valid0 !== m_rv || r_data0 !== m_rd) begin errors++; $display("FAIL rnd_rdata cyc=%0d act=%h/%b exp=%h/%b", i, r_data0, r_valid0, m_rd, m_rv); end
      checks++; if (r_valid1 !== (n > 0) || (n > 0 && r_data1 !== q[0])) begin errors++; $display("FAIL rnd_fwft cyc=%0d act=%h/%b exp=%h/%b", i, r_data1, r_valid1, n > 0 ? q[0] : 8'h00, n > 0); end
    end
    for (int i = 0; i < 3; i++) drive(1, 0, 8'(8'hE0 + i), 0);
    rst = 1;
    #1;
    checks++; if (count0 !== 5'd0 || empty0 !== 1'b1 || count1 !== 5'd0 || r_valid1 !== 1'b0) begin errors++; $display("FAIL mid_reset act=%0d/%b/%0d/%b exp=0/1/0/0", count0, empty0, count1, r_valid1); end
    q.delete(); m_rd = 0; m_rv = 0; m_ovf = 0; m_udf = 0;
    @(negedge clk);
    rst = 0;
    drive(1, 0, 8'h77, 0);
    drive(0, 1, 8'h00, 0);
    checks++; if (r_data0 !== 8'h77 || r_valid0 !== 1'b1 || empty0 !== 1'b1) begin errors++; $display("FAIL post_reset act=%h/%b/%b exp=77/1/1", r_data0, r_valid0, empty0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_fwft();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
